cond_flag_unit: RTL and testbench

- Consumer end of the ALU flag interface. Holds the architectural NZCV register and evaluates the 4-bit ARM condition field of each issuing instruction to produce CondEx.
- Drives the ALU Carry input and commits the ALU's returned NZCV flags ({N,Z,C,V}, NZ in [3:2], CV in [1:0]) under per-group write enables.
- Tracks in-flight flag writers in a small FIFO and stalls dependent conditional instructions.

---
 rtl/cond_pkg.sv | 36 +++
 rtl/cond_flag_unit_flagw_fifo.sv | 33 +++
 rtl/cond_flag_unit.sv | 62 ++++++
 tb/tb_cond_flag_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: ARM condition codes, NZCV/FlagW bit indices and the shared condition evaluator
// Macro FLAG_BYPASS_EN (used by cond_flag_unit) selects same-cycle flag bypass.
package cond_pkg;
    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3;
    localparam logic [3:0] MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7;
    localparam logic [3:0] HI = 4'h8, LS = 4'h9, GE = 4'ha, LT = 4'hb;
    localparam logic [3:0] GT = 4'hc, LE = 4'hd, AL = 4'he, NV = 4'hf;
    localparam int N_BIT = 3, Z_BIT = 2, C_BIT = 1, V_BIT = 0;
    localparam int FW_NZ = 1, FW_CV = 0;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[N_BIT];
        z = nzcv[Z_BIT];
        c = nzcv[C_BIT];
        v = nzcv[V_BIT];
        case (cond)
            EQ: cond_pass = z;
            NE: cond_pass = !z;
            CS: cond_pass = c;
            CC: cond_pass = !c;
            MI: cond_pass = n;
            PL: cond_pass = !n;
            VS: cond_pass = v;
            VC: cond_pass = !v;
            HI: cond_pass = c & !z;
            LS: cond_pass = !c | z;
            GE: cond_pass = n == v;
            LT: cond_pass = n != v;
            GT: cond_pass = !z & (n == v);
            LE: cond_pass = z | (n != v);
            AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/cond_flag_unit_flagw_fifo.sv
// flagw_fifo: DEPTH-deep FIFO of 2-bit flag-write masks for in-flight flag writers
// Ports: clk, rst_n (async active-low), push/din enqueue, pop dequeue, head = oldest mask, count = occupancy.
// Callers only pop when count>0 and only push into a full FIFO together with a pop.
module flagw_fifo #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] head,
    output logic [2:0] count
);
    logic [1:0] mem [DEPTH];
    logic [1:0] wr, rd;
    logic [1:0] wr_nxt, rd_nxt;
    assign wr_nxt = wr == 2'(DEPTH - 1) ? 2'd0 : wr + 2'd1;
    assign rd_nxt = rd == 2'(DEPTH - 1) ? 2'd0 : rd + 2'd1;
    assign head = mem[rd];
    always_ff @(posedge clk)
        if (push) mem[wr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr_nxt;
            if (pop) rd <= rd_nxt;
            count <= count + 3'(push) - 3'(pop);
        end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV register, condition evaluation, flag-writer tracking and dependency stall
// Ports: CLK, RESETn (async active-low); issue side Iss_Valid/Iss_Cond/Iss_FlagW/Iss_Carry_use -> Iss_Ready, CondEx;
// Carry to the ALU; result side Res_Valid/ALUFlags; status Flags, Pending, Err (sticky pop-on-empty).
// Macro FLAG_BYPASS_EN: when defined, returning ALU flags for the last in-flight writer are visible
// to CondEx/Carry in the same cycle; otherwise dependents wait for the registered Flags.
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter int MAXPEND = 3
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       Iss_Valid,
    input  logic [3:0] Iss_Cond,
    input  logic [1:0] Iss_FlagW,
    input  logic       Iss_Carry_use,
    output logic       Iss_Ready,
    output logic       CondEx,
    output logic       Carry,
    input  logic       Res_Valid,
    input  logic [3:0] ALUFlags,
    output logic [3:0] Flags,
    output logic [2:0] Pending,
    output logic       Err
);
    logic [1:0] head;
    logic [2:0] count;
    logic       pop, push, byp, dep;
    logic [3:0] merged, eff;
    assign pop = Res_Valid & (count != 3'd0);
    assign merged = {head[FW_NZ] ? ALUFlags[3:2] : Flags[3:2],
                     head[FW_CV] ? ALUFlags[1:0] : Flags[1:0]};
`ifdef FLAG_BYPASS_EN
    assign byp = Res_Valid & (count == 3'd1);
`else
    assign byp = 1'b0;
`endif
    assign eff = byp ? merged : Flags;
    assign Carry = eff[C_BIT];
    assign dep = (Iss_Cond != AL) | Iss_Carry_use;
    assign Iss_Ready = !((count == 3'(MAXPEND) && !pop) || (dep && count != 3'd0 && !byp));
    assign CondEx = cond_pass(Iss_Cond, eff) & Iss_Valid & Iss_Ready;
    assign push = CondEx & |Iss_FlagW;
    assign Pending = count;
    flagw_fifo #(.DEPTH(MAXPEND)) u_fifo (
        .clk  (CLK),
        .rst_n(RESETn),
        .push (push),
        .pop  (pop),
        .din  (Iss_FlagW),
        .head (head),
        .count(count)
    );
    always_ff @(posedge CLK or negedge RESETn)
        if (!RESETn) begin
            Flags <= 4'b0000;
            Err <= 1'b0;
        end else begin
            if (pop) Flags <= merged;
            if (Res_Valid && count == 3'd0) Err <= 1'b1;
        end
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed + random stimulus against a queue-based reference model, scoreboard checked
module tb_cond_flag_unit;
    logic       CLK = 1'b0;
    logic       RESETn = 1'b1;
    logic       Iss_Valid = 1'b0;
    logic [3:0] Iss_Cond = 4'he;
    logic [1:0] Iss_FlagW = 2'b00;
    logic       Iss_Carry_use = 1'b0;
    logic       Iss_Ready, CondEx, Carry, Err;
    logic       Res_Valid = 1'b0;
    logic [3:0] ALUFlags = 4'b0000;
    logic [3:0] Flags;
    logic [2:0] Pending;

    localparam int MAXP = 3;
`ifdef FLAG_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    cond_flag_unit #(.MAXPEND(MAXP)) dut (
        .CLK(CLK), .RESETn(RESETn), .Iss_Valid(Iss_Valid), .Iss_Cond(Iss_Cond),
        .Iss_FlagW(Iss_FlagW), .Iss_Carry_use(Iss_Carry_use), .Iss_Ready(Iss_Ready),
        .CondEx(CondEx), .Carry(Carry), .Res_Valid(Res_Valid), .ALUFlags(ALUFlags),
        .Flags(Flags), .Pending(Pending), .Err(Err)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct {
        logic       rdy, cx, carry, err;
        logic [3:0] flags;
        logic [2:0] pend;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] mq[$];
    logic [3:0] m_flags = 4'b0000;
    logic       m_err = 1'b0;
    int         checks = 0;
    int         errors = 0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ARM rule: even codes test a base predicate, odd codes test its inverse; 1111 never passes.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, b;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = n == v;
            3'd6: b = !z && n == v;
            default: b = 1'b1;
        endcase
        return c == 4'hf ? 1'b0 : (b ^ c[0]);
    endfunction

    task automatic step(input bit v, input logic [3:0] c, input logic [1:0] fw, input bit cu,
                        input bit rv, input logic [3:0] alu, input bit rn = 1'b1);
        int         cnt;
        bit         pop, byp, dep, rdy, cx;
        logic [3:0] e, upd;
        exp_t       x;
        @(posedge CLK);
        #1;
        RESETn = rn; Iss_Valid = v; Iss_Cond = c; Iss_FlagW = fw; Iss_Carry_use = cu;
        Res_Valid = rv; ALUFlags = alu;
        if (!rn) begin
            mq.delete();
            m_flags = 4'b0000;
            m_err = 1'b0;
        end
        cnt = mq.size();
        pop = rn && rv && cnt > 0;
        upd = m_flags;
        if (pop) begin
            if (mq[0][1]) upd[3:2] = alu[3:2];
            if (mq[0][0]) upd[1:0] = alu[1:0];
        end
        byp = BYP && rv && cnt == 1;
        e = byp ? upd : m_flags;
        dep = c != 4'he || cu;
        rdy = !((cnt == MAXP && !pop) || (dep && cnt > 0 && !byp));
        cx = ref_pass(c, e) && v && rdy;
        x.rdy = rdy; x.cx = cx; x.carry = e[1];
        x.flags = m_flags; x.pend = 3'(cnt); x.err = m_err;
        sbq.push_back(x);
        if (rn) begin
            if (pop) begin
                m_flags = upd;
                void'(mq.pop_front());
            end
            if (cx && fw != 2'b00) mq.push_back(fw);
            if (rv && cnt == 0) m_err = 1'b1;
        end
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) step(0, 4'he, 2'b00, 0, 0, 4'h0);
    endtask

    always @(negedge CLK)
        if (sbq.size() != 0) begin
            exp_t x;
            x = sbq.pop_front();
            chk("iss_ready", 8'(Iss_Ready), 8'(x.rdy));
            chk("condex", 8'(CondEx), 8'(x.cx));
            chk("carry", 8'(Carry), 8'(x.carry));
            chk("flags", 8'(Flags), 8'(x.flags));
            chk("pending", 8'(Pending), 8'(x.pend));
            chk("err", 8'(Err), 8'(x.err));
        end

    task automatic direct_chk(input string name, input logic [7:0] act_sel, input logic [7:0] exp);
        @(negedge CLK);
        #1;
        case (act_sel)
            8'd0: chk(name, 8'(Flags), exp);
            8'd1: chk(name, 8'(Err), exp);
            default: chk(name, 8'(Pending), exp);
        endcase
    endtask

    initial begin
        step(0, 4'he, 2'b00, 0, 0, 4'h0, 1'b0);
        idle(1);
        // flag-setting SUB then dependent EQ in the result cycle
        step(1, 4'he, 2'b11, 0, 0, 4'h0);
        step(1, 4'h0, 2'b00, 0, 1, 4'b0100);
        step(1, 4'h0, 2'b00, 0, 0, 4'h0);
        // partial NZ-only write
        step(1, 4'he, 2'b11, 0, 0, 4'h0);
        step(0, 4'he, 2'b00, 0, 1, 4'b1111);
        step(1, 4'he, 2'b10, 0, 0, 4'h0);
        step(0, 4'he, 2'b00, 0, 1, 4'b0000);
        idle(1);
        direct_chk("partial_write", 8'd0, 8'h03);
        // fill the FIFO, then a 4th writer and a dependent GT stall
        for (int i = 0; i < 3; i++) step(1, 4'he, 2'b01, 0, 0, 4'h0);
        step(1, 4'he, 2'b11, 0, 0, 4'h0);
        step(1, 4'hc, 2'b00, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(1, 4'hc, 2'b00, 0, 1, 4'b0000);
        step(1, 4'hc, 2'b00, 0, 0, 4'h0);
        // full FIFO with same-cycle pop accepts a push
        for (int i = 0; i < 3; i++) step(1, 4'he, 2'b01, 0, 0, 4'h0);
        step(1, 4'he, 2'b01, 0, 1, 4'b0010);
        for (int i = 0; i < 3; i++) step(0, 4'he, 2'b00, 0, 1, 4'b0010);
        // carry path: C=1 in Flags, pending writer returns C=0 alongside an ADC
        step(1, 4'he, 2'b01, 0, 0, 4'h0);
        step(1, 4'he, 2'b00, 1, 1, 4'b0000);
        idle(1);
        // pop on empty and the never condition
        step(0, 4'he, 2'b00, 0, 1, 4'b1010);
        idle(2);
        direct_chk("err_sticky", 8'd1, 8'h01);
        step(1, 4'hf, 2'b11, 0, 0, 4'h0);
        direct_chk("never_no_push", 8'd2, 8'h00);
        // reset mid-stream with two writers in flight
        step(1, 4'he, 2'b11, 0, 0, 4'h0);
        step(1, 4'he, 2'b01, 0, 0, 4'h0);
        step(0, 4'he, 2'b00, 0, 0, 4'h0, 1'b0);
        step(1, 4'h0, 2'b00, 0, 0, 4'h0);
        step(1, 4'h1, 2'b00, 0, 0, 4'h0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(0, 4'he, 2'b00, 0, 0, 4'h0, 1'b0);
            else
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) == 0 ? 4'he : 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                     $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
        end
        idle(1);
        @(negedge CLK);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
